// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ writeback sources.
// Optional same-cycle read bypass of the committing write is enabled by defining RF_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         writeRegSel,
  output logic [DATA_W-1:0]         writeData,
  output logic                      writeEn,
  output logic                      err
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [2*ADDR_W-1:0]       byp_sel,
  output logic [1:0]                byp_hit,
  output logic [2*DATA_W-1:0]       byp_data
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]          r_rr_ptr;
  logic                      r_write_en;
  logic [ADDR_W-1:0]         r_write_sel;
  logic [DATA_W-1:0]         r_write_data;
  logic                      r_err;
  logic [NUM_REQ-1:0]        r_pend;
  logic [NUM_REQ*ADDR_W-1:0] r_pend_addr;
  logic [NUM_REQ*DATA_W-1:0] r_pend_data;

  logic                      w_found;
  logic                      w_grant;
  logic [PTR_W-1:0]          w_grant_idx;
  logic [ADDR_W-1:0]         w_grant_addr;
  logic [DATA_W-1:0]         w_grant_data;
  logic [NUM_REQ-1:0]        w_viol;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  // Scan from the farthest offset down so the valid requester closest to rr_ptr wins.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_found     = 1'b1;
        w_grant_idx = wrap_add(r_rr_ptr, k);
      end
    end
  end

  assign w_grant      = w_found & rst;
  assign w_grant_addr = req_addr[w_grant_idx*ADDR_W +: ADDR_W];
  assign w_grant_data = req_data[w_grant_idx*DATA_W +: DATA_W];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_ready[gi] = w_grant & (w_grant_idx == PTR_W'(gi));
      // A requester left waiting last cycle must still present the same request now.
      assign w_viol[gi] = r_pend[gi] &
                          (~req_valid[gi] |
                           (req_addr[gi*ADDR_W +: ADDR_W] != r_pend_addr[gi*ADDR_W +: ADDR_W]) |
                           (req_data[gi*DATA_W +: DATA_W] != r_pend_data[gi*DATA_W +: DATA_W]));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr     <= '0;
      r_write_en   <= 1'b0;
      r_write_sel  <= '0;
      r_write_data <= '0;
    end else begin
      r_write_en <= w_grant & (w_grant_addr != '0);
      if (w_grant) begin
        r_write_sel  <= w_grant_addr;
        r_write_data <= w_grant_data;
        r_rr_ptr     <= wrap_add(w_grant_idx, 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= req_valid & ~req_ready;
      if (|w_viol) r_err <= 1'b1;
    end
    r_pend_addr <= req_addr;
    r_pend_data <= req_data;
  end

  assign writeEn     = r_write_en;
  assign writeRegSel = r_write_sel;
  assign writeData   = r_write_data;
  assign err         = r_err;

`ifdef RF_WB_BYPASS_EN
  generate
    for (gi = 0; gi < 2; gi++) begin : g_byp
      assign byp_hit[gi] = r_write_en & (r_write_sel != '0) &
                           (r_write_sel == byp_sel[gi*ADDR_W +: ADDR_W]);
      assign byp_data[gi*DATA_W +: DATA_W] = r_write_data;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, hand-written corner sequences,
// and randomized traffic compared against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   writeRegSel;
  logic [DW-1:0]   writeData;
  logic            writeEn;
  logic            err;
`ifdef RF_WB_BYPASS_EN
  logic [2*AW-1:0] byp_sel = '0;
  logic [1:0]      byp_hit;
  logic [2*DW-1:0] byp_data;
`endif

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .writeRegSel(writeRegSel), .writeData(writeData),
    .writeEn(writeEn), .err(err)
`ifdef RF_WB_BYPASS_EN
    , .byp_sel(byp_sel), .byp_hit(byp_hit), .byp_data(byp_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model state
  int          m_ptr = 0;
  logic        m_we = 0;
  logic [4:0]  m_sel = 0;
  logic [31:0] m_data = 0;
  logic        m_err = 0;
  logic [2:0]  m_rdy = 0;
  bit          m_wait [N];
  logic [4:0]  m_wa   [N];
  logic [31:0] m_wd   [N];

  task automatic model_step(input logic r, input logic [2:0] v, input logic [14:0] a, input logic [95:0] d);
    int g;
    g = -1;
    if (!r) begin
      m_rdy = 0; m_ptr = 0; m_we = 0; m_sel = 0; m_data = 0; m_err = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      return;
    end
    for (int k = 0; k < N; k++)
      if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    m_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
    for (int i = 0; i < N; i++)
      if (m_wait[i] && (!v[i] || a[i*AW +: AW] != m_wa[i] || d[i*DW +: DW] != m_wd[i])) m_err = 1;
    for (int i = 0; i < N; i++) begin
      m_wait[i] = v[i] && (i != g);
      m_wa[i]   = a[i*AW +: AW];
      m_wd[i]   = d[i*DW +: DW];
    end
    if (g >= 0) begin
      m_we   = (a[g*AW +: AW] != 0);
      m_sel  = a[g*AW +: AW];
      m_data = d[g*DW +: DW];
      m_ptr  = (g + 1) % N;
    end else begin
      m_we = 0;
    end
  endtask

  // Called at posedge+1; returns combinational ready and post-edge registered outputs.
  task automatic run_cycle(input logic r, input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                           output logic [2:0] rdy, output logic we, output logic [4:0] sel,
                           output logic [31:0] dat, output logic e);
    rst = r; req_valid = v; req_addr = a; req_data = d;
    #4;
    rdy = req_ready;
    model_step(r, v, a, d);
    @(posedge clk);
    #1;
    we = writeEn; sel = writeRegSel; dat = writeData; e = err;
  endtask

  typedef struct {
    logic        r;
    logic [2:0]  v;
    logic [14:0] a;
    logic [95:0] d;
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  sel;
    logic [31:0] dat;
    logic        e;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                              input logic [2:0] rdy, input logic we, input logic [4:0] sel,
                              input logic [31:0] dat, input logic e);
    vec_t t;
    t.r = r; t.v = v; t.a = a; t.d = d; t.rdy = rdy; t.we = we; t.sel = sel; t.dat = dat; t.e = e;
    return t;
  endfunction

  vec_t tbl [17];

  initial begin
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  sel;
    logic [31:0] dat;
    logic        e;
    logic [14:0] a123;
    logic [95:0] d123;
    logic        cur_v [N];
    logic [4:0]  cur_a [N];
    logic [31:0] cur_d [N];
    logic [2:0]  pv;
    logic [14:0] pa;
    logic [95:0] pd;
    logic        r;

    a123 = {5'd3, 5'd2, 5'd1};
    d123 = {32'h102, 32'h101, 32'h100};
    tbl[0]  = mk(0, 3'b111, a123, d123, 3'b000, 0, 0, 0, 0);
    tbl[1]  = mk(0, 3'b111, a123, d123, 3'b000, 0, 0, 0, 0);
    tbl[2]  = mk(1, 3'b001, {10'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 3'b001, 1, 5, 32'hDEADBEEF, 0);
    tbl[3]  = mk(1, 3'b000, {10'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 3'b000, 0, 5, 32'hDEADBEEF, 0);
    tbl[4]  = mk(0, 3'b000, a123, d123, 3'b000, 0, 0, 0, 0);
    tbl[5]  = mk(1, 3'b111, a123, d123, 3'b001, 1, 1, 32'h100, 0);
    tbl[6]  = mk(1, 3'b111, a123, d123, 3'b010, 1, 2, 32'h101, 0);
    tbl[7]  = mk(1, 3'b111, a123, d123, 3'b100, 1, 3, 32'h102, 0);
    tbl[8]  = mk(1, 3'b111, a123, d123, 3'b001, 1, 1, 32'h100, 0);
    tbl[9]  = mk(1, 3'b111, a123, d123, 3'b010, 1, 2, 32'h101, 0);
    tbl[10] = mk(1, 3'b111, a123, d123, 3'b100, 1, 3, 32'h102, 0);
    tbl[11] = mk(0, 3'b111, a123, d123, 3'b000, 0, 0, 0, 0);
    tbl[12] = mk(1, 3'b010, {5'd3, 5'd0, 5'd1}, {32'h102, 32'h1234, 32'h100}, 3'b010, 0, 0, 32'h1234, 0);
    tbl[13] = mk(1, 3'b111, a123, d123, 3'b100, 1, 3, 32'h102, 0);
    tbl[14] = mk(1, 3'b011, a123, d123, 3'b001, 1, 1, 32'h100, 0);
    tbl[15] = mk(1, 3'b010, a123, d123, 3'b010, 1, 2, 32'h101, 0);
    tbl[16] = mk(1, 3'b000, a123, d123, 3'b000, 0, 2, 32'h101, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) begin
      run_cycle(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].d, rdy, we, sel, dat, e);
      $display("vec %0d: ready=%b we=%b sel=%0d data=%h err=%b", i, rdy, we, sel, dat, e);
      chk($sformatf("vec%0d_ready", i), rdy, tbl[i].rdy);
      chk($sformatf("vec%0d_we", i), we, tbl[i].we);
      chk($sformatf("vec%0d_sel", i), sel, tbl[i].sel);
      chk($sformatf("vec%0d_data", i), dat, tbl[i].dat);
      chk($sformatf("vec%0d_err", i), e, tbl[i].e);
    end

    // Waiting requester changes its data: err rises and sticks until reset.
    run_cycle(0, 3'b000, a123, d123, rdy, we, sel, dat, e);
    run_cycle(1, 3'b011, a123, d123, rdy, we, sel, dat, e);
    chk("perr_grant0", rdy, 3'b001);
    chk("perr_before", e, 0);
    run_cycle(1, 3'b010, a123, {32'h102, 32'hBAD, 32'h100}, rdy, we, sel, dat, e);
    $display("proto data change: ready=%b err=%b", rdy, e);
    chk("perr_still_arb", rdy, 3'b010);
    chk("perr_set", e, 1);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1, 3'b000, a123, d123, rdy, we, sel, dat, e);
      chk($sformatf("perr_sticky%0d", i), e, 1);
    end
    run_cycle(0, 3'b000, a123, d123, rdy, we, sel, dat, e);
    chk("perr_cleared", e, 0);

    // Waiting requester drops valid.
    run_cycle(1, 3'b011, a123, d123, rdy, we, sel, dat, e);
    run_cycle(1, 3'b000, a123, d123, rdy, we, sel, dat, e);
    $display("proto drop valid: err=%b", e);
    chk("pdrop_set", e, 1);

    // Reset arriving right after a grant cancels the pending write.
    run_cycle(0, 3'b000, a123, d123, rdy, we, sel, dat, e);
    run_cycle(1, 3'b001, {10'd0, 5'd9}, d123, rdy, we, sel, dat, e);
    chk("rmid_we_before", we, 1);
    run_cycle(0, 3'b111, a123, d123, rdy, we, sel, dat, e);
    $display("reset mid-op: ready=%b we=%b sel=%0d", rdy, we, sel);
    chk("rmid_ready", rdy, 3'b000);
    chk("rmid_we", we, 0);
    chk("rmid_sel", sel, 0);

`ifdef RF_WB_BYPASS_EN
    run_cycle(1, 3'b100, {5'd7, 10'd0}, {32'hA5A5A5A5, 64'd0}, rdy, we, sel, dat, e);
    byp_sel = {5'd0, 5'd7};
    #1;
    $display("bypass: hit=%b data0=%h", byp_hit, byp_data[31:0]);
    chk("byp_hit_slot0", byp_hit, 2'b01);
    chk("byp_data0", byp_data[31:0], 32'hA5A5A5A5);
    byp_sel = {5'd7, 5'd7};
    #1;
    chk("byp_hit_both", byp_hit, 2'b11);
    byp_sel = {5'd3, 5'd6};
    #1;
    chk("byp_hit_none", byp_hit, 2'b00);
    byp_sel = {5'd7, 5'd7};
    run_cycle(0, 3'b000, a123, d123, rdy, we, sel, dat, e);
    #1;
    chk("byp_hit_reset", byp_hit, 2'b00);
`endif

    // Randomized traffic against the behavioural model.
    for (int i = 0; i < N; i++) begin
      cur_v[i] = 0; cur_a[i] = 0; cur_d[i] = 0;
    end
    for (int c = 0; c < 500; c++) begin
      r = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      for (int i = 0; i < N; i++) begin
        if (m_wait[i]) begin
          if ($urandom_range(0, 199) == 0) cur_d[i] = cur_d[i] ^ 32'h1;
        end else begin
          cur_v[i] = ($urandom_range(0, 99) < 55);
          cur_a[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
          cur_d[i] = $urandom;
        end
        pv[i] = cur_v[i];
        pa[i*AW +: AW] = cur_a[i];
        pd[i*DW +: DW] = cur_d[i];
      end
      run_cycle(r, pv, pa, pd, rdy, we, sel, dat, e);
      $display("rnd %0d: rst=%b valid=%b ready=%b we=%b sel=%0d data=%h err=%b",
               c, r, pv, rdy, we, sel, dat, e);
      chk($sformatf("rnd%0d_ready", c), rdy, m_rdy);
      chk($sformatf("rnd%0d_we", c), we, m_we);
      chk($sformatf("rnd%0d_sel", c), sel, m_sel);
      chk($sformatf("rnd%0d_data", c), dat, m_data);
      chk($sformatf("rnd%0d_err", c), e, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
